// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// riscv_defines
// Shared widths and types for the instruction fetch slice.
//   RISCV_WORD_WIDTH  : instruction word width
//   RISCV_ADDR_WIDTH  : byte address width
//   RISCV_INSTR_BYTES : bytes per fetched instruction word
//   fetch_entry_t     : prefetch FIFO entry {addr, instr}
//   FETCH_RUN/FLUSH   : fetch control FSM encodings
// -----------------------------------------------------------------------------
package riscv_defines;

    localparam int RISCV_WORD_WIDTH  = 32;
    localparam int RISCV_ADDR_WIDTH  = 32;
    localparam int RISCV_INSTR_BYTES = 4;

    typedef struct packed {
        logic [RISCV_ADDR_WIDTH-1:0] addr;
        logic [RISCV_WORD_WIDTH-1:0] instr;
    } fetch_entry_t;

    localparam logic [0:0] FETCH_RUN   = 1'b0;
    localparam logic [0:0] FETCH_FLUSH = 1'b1;

endpackage

// File: rtl/fetch_stage_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Prefetch FIFO holding fetched words tagged with their address.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data at the tail
//   pop         : drop the head entry
//   flush       : empty the FIFO (wins over push and pop)
//   push_data   : entry to write
//   head        : current head entry (reset value {RST_ADDR, 0})
//   count       : number of valid entries
//   full, empty : occupancy flags
// -----------------------------------------------------------------------------
module fetch_fifo
    import riscv_defines::*;
#(
    parameter int                          DEPTH    = 2,
    parameter logic [RISCV_ADDR_WIDTH-1:0] RST_ADDR = '0,
    localparam int                         CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     push_data,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage is reset too so the decoder-facing outputs have defined
    // values straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= fetch_entry_t'{addr: RST_ADDR, instr: '0};
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop && !flush));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && empty && !flush));
`endif

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch: issues word requests, buffers responses in a prefetch
// FIFO and presents them to the decoder; handles branch/jump redirects.
//   clk, rst_n          : clock, asynchronous active-low reset
//   instr_mem_req_o     : memory request (held with address until gnt)
//   instr_mem_addr_o    : request address, word aligned
//   instr_mem_gnt_i     : request accepted this cycle
//   instr_mem_rvalid_i  : in-order response valid
//   instr_mem_rdata_i   : response word
//   instr_o, pc_o       : FIFO head word and its address
//   instr_valid_o       : head valid
//   instr_req_i         : decoder consumes head
//   target_addr_i       : redirect address (bits [1:0] ignored)
//   target_valid_i      : redirect strobe
// -----------------------------------------------------------------------------
module fetch_stage
    import riscv_defines::*;
#(
    parameter logic [RISCV_ADDR_WIDTH-1:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int                          FIFO_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        instr_mem_req_o,
    output logic [RISCV_ADDR_WIDTH-1:0] instr_mem_addr_o,
    input  logic                        instr_mem_gnt_i,
    input  logic                        instr_mem_rvalid_i,
    input  logic [RISCV_WORD_WIDTH-1:0] instr_mem_rdata_i,
    output logic [RISCV_WORD_WIDTH-1:0] instr_o,
    output logic                        instr_valid_o,
    output logic [RISCV_ADDR_WIDTH-1:0] pc_o,
    input  logic                        instr_req_i,
    input  logic [RISCV_ADDR_WIDTH-1:0] target_addr_i,
    input  logic                        target_valid_i
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [RISCV_ADDR_WIDTH-1:0] STEP = RISCV_ADDR_WIDTH'(RISCV_INSTR_BYTES);

    logic [0:0]                  state_q, state_d;
    logic [RISCV_ADDR_WIDTH-1:0] npc_q, npc_d;
    logic [RISCV_ADDR_WIDTH-1:0] rpc_q, rpc_d;
    logic [RISCV_ADDR_WIDTH-1:0] stale_addr_q, stale_addr_d;
    logic                        req_q, req_d;
    logic                        stale_q, stale_d;
    logic [CNT_W-1:0]            out_q, out_d;
    logic [CNT_W-1:0]            disc_cnt_q, disc_cnt_d;
    logic [CNT_W-1:0]            cnt_d;
    logic [CNT_W:0]              level_d;
    logic [RISCV_ADDR_WIDTH-1:0] target_aligned;

    logic                        gnt_fire;
    logic                        redirect;
    logic                        push;
    logic                        pop;
    fetch_entry_t                head;
    fetch_entry_t                push_entry;
    logic [CNT_W-1:0]            fifo_count;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        unused_bits;

    assign unused_bits    = ^{target_addr_i[1:0], fifo_full};
    assign target_aligned = {target_addr_i[RISCV_ADDR_WIDTH-1:2], 2'b00};

    assign gnt_fire = req_q & instr_mem_gnt_i;
    assign redirect = target_valid_i;
    // Redirect wins over both pop and push in the same cycle.
    assign pop      = ~fifo_empty & instr_req_i & ~redirect;
    assign push     = instr_mem_rvalid_i & (state_q == FETCH_RUN) & ~redirect;

    // Live responses arrive in order starting at the last redirect target,
    // so a running counter tags each pushed word with its address.
    assign push_entry = fetch_entry_t'{addr: rpc_q, instr: instr_mem_rdata_i};

    fetch_fifo #(
        .DEPTH    (FIFO_DEPTH),
        .RST_ADDR (BOOT_ADDR)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (redirect),
        .push_data (push_entry),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        out_d = out_q;
        if (gnt_fire && !instr_mem_rvalid_i) begin
            out_d = out_q + CNT_W'(1);
        end else if (!gnt_fire && instr_mem_rvalid_i) begin
            out_d = out_q - CNT_W'(1);
        end

        cnt_d = fifo_count;
        if (redirect) begin
            cnt_d = '0;
        end else if (push && !pop) begin
            cnt_d = fifo_count + CNT_W'(1);
        end else if (!push && pop) begin
            cnt_d = fifo_count - CNT_W'(1);
        end

        // Every word in flight after this cycle predates the redirect. A
        // stale pending request joins the count only once it is granted.
        disc_cnt_d = disc_cnt_q;
        if (redirect) begin
            disc_cnt_d = out_d;
        end else begin
            if (instr_mem_rvalid_i && (disc_cnt_q != '0)) begin
                disc_cnt_d = disc_cnt_d - CNT_W'(1);
            end
            if (gnt_fire && stale_q) begin
                disc_cnt_d = disc_cnt_d + CNT_W'(1);
            end
        end

        npc_d = npc_q;
        if (redirect) begin
            npc_d = target_aligned;
        end else if (gnt_fire && !stale_q) begin
            npc_d = npc_q + STEP;
        end

        stale_d      = stale_q;
        stale_addr_d = stale_addr_q;
        if (gnt_fire) begin
            stale_d = 1'b0;
        end
        if (redirect && req_q && !instr_mem_gnt_i) begin
            stale_d = 1'b1;
            if (!stale_q) begin
                stale_addr_d = npc_q;
            end
        end

        rpc_d = rpc_q;
        if (redirect) begin
            rpc_d = target_aligned;
        end else if (push) begin
            rpc_d = rpc_q + STEP;
        end

        level_d = {1'b0, cnt_d} + {1'b0, out_d};
        if (req_q && !instr_mem_gnt_i) begin
            req_d = 1'b1;
        end else begin
            req_d = (level_d < (CNT_W + 1)'(FIFO_DEPTH));
        end

        state_d = (disc_cnt_d != '0) ? FETCH_FLUSH : FETCH_RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH_RUN;
            npc_q        <= BOOT_ADDR;
            rpc_q        <= BOOT_ADDR;
            stale_addr_q <= BOOT_ADDR;
            req_q        <= 1'b0;
            stale_q      <= 1'b0;
            out_q        <= '0;
            disc_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            npc_q        <= npc_d;
            rpc_q        <= rpc_d;
            stale_addr_q <= stale_addr_d;
            req_q        <= req_d;
            stale_q      <= stale_d;
            out_q        <= out_d;
            disc_cnt_q   <= disc_cnt_d;
        end
    end

    assign instr_mem_req_o  = req_q;
    assign instr_mem_addr_o = stale_q ? stale_addr_q : npc_q;
    assign instr_valid_o    = ~fifo_empty;
    assign instr_o          = head.instr;
    assign pc_o             = head.addr;

`ifndef SYNTHESIS
    a_rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        !(instr_mem_rvalid_i && (out_q == '0)));
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic        instr_req;
    logic [31:0] target_addr;
    logic        target_valid;

    logic        rv_en;
    logic        fire_s;
    logic [31:0] fire_a;
    logic [31:0] mem_q[$];
    logic [31:0] exp_q[$];

    int checks = 0;
    int errors = 0;

    fetch_stage #(.BOOT_ADDR(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .instr_mem_req_o    (mem_req),
        .instr_mem_addr_o   (mem_addr),
        .instr_mem_gnt_i    (mem_gnt),
        .instr_mem_rvalid_i (mem_rvalid),
        .instr_mem_rdata_i  (mem_rdata),
        .instr_o            (instr),
        .instr_valid_o      (instr_valid),
        .pc_o               (pc),
        .instr_req_i        (instr_req),
        .target_addr_i      (target_addr),
        .target_valid_i     (target_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic redirect(input logic [31:0] a);
        target_addr  = a;
        target_valid = 1'b1;
        step(1);
        target_valid = 1'b0;
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step(1);
            n++;
        end
        instr_req = 1'b0;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected words not delivered within %0d cycles", exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    // Memory model: capture grants mid-cycle, answer in order from the
    // following cycle whenever rv_en allows. Response word is ~address.
    initial begin
        fire_s = 1'b0;
        fire_a = '0;
        forever begin
            @(negedge clk);
            fire_s = rst_n && mem_req && mem_gnt;
            fire_a = mem_addr;
        end
    end

    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                mem_q.delete();
                mem_rvalid = 1'b0;
            end else begin
                if (fire_s) mem_q.push_back(fire_a);
                if (rv_en && mem_q.size() != 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = ~mem_q.pop_front();
                end else begin
                    mem_rvalid = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: every word the decoder consumes is checked in order.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && instr_valid && instr_req && !target_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got pc %h, expected no consumption", pc);
                end else begin
                    e = exp_q.pop_front();
                    if (pc !== e || instr !== ~e) begin
                        errors++;
                        $display("FAIL sb_word: got pc %h instr %h, expected pc %h instr %h", pc, instr, e, ~e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        mem_gnt      = 1'b1;
        rv_en        = 1'b1;
        instr_req    = 1'b1;
        target_addr  = '0;
        target_valid = 1'b0;

        // Reset state and first fetch latency
        step(2);
        chk("rst_req",   32'(mem_req), 32'd0);
        chk("rst_addr",  mem_addr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc",    pc, 32'h0);
        push_seq(32'h0, 8);
        rst_n = 1'b1;
        step(1);
        chk("c1_req",  32'(mem_req), 32'd1);
        chk("c1_addr", mem_addr, 32'h0);
        step(1);
        chk("c2_valid", 32'(instr_valid), 32'd0);
        step(1);
        chk("c3_valid", 32'(instr_valid), 32'd1);
        chk("c3_pc",    pc, 32'h0);
        drain(60);

        // Decoder stall: buffer fills, request drops, head stable
        step(6);
        chk("stall_req",   32'(mem_req), 32'd0);
        chk("stall_valid", 32'(instr_valid), 32'd1);
        chk("stall_pc",    pc, 32'h20);
        chk("stall_instr", instr, ~32'h20);
        step(3);
        chk("stall_pc_hold", pc, 32'h20);
        push_seq(32'h20, 8);
        instr_req = 1'b1;
        drain(60);

        // Redirect with two responses in flight
        step(5);
        rv_en = 1'b0;
        redirect(32'h80);
        step(3);
        chk("flush_valid", 32'(instr_valid), 32'd0);
        chk("inflight_req", 32'(mem_req), 32'd0);
        instr_req = 1'b1;
        redirect(32'h100);
        chk("disc_two",   32'(dut.disc_cnt_q), 32'd2);
        chk("state_flush", 32'(dut.state_q), 32'd1);
        push_seq(32'h100, 4);
        rv_en = 1'b1;
        drain(60);
        chk("disc_zero", 32'(dut.disc_cnt_q), 32'd0);
        chk("state_run", 32'(dut.state_q), 32'd0);

        // Redirect while a request is pending ungranted
        step(5);
        mem_gnt = 1'b0;
        redirect(32'h20);
        chk("pend_req",  32'(mem_req), 32'd1);
        chk("pend_addr", mem_addr, 32'h20);
        redirect(32'h202);
        chk("stale_addr_a", mem_addr, 32'h20);
        step(1);
        chk("stale_addr_b", mem_addr, 32'h20);
        mem_gnt = 1'b1;
        step(1);
        chk("new_req",   32'(mem_req), 32'd1);
        chk("new_addr",  mem_addr, 32'h200);
        chk("stale_disc", 32'(dut.disc_cnt_q), 32'd1);
        push_seq(32'h200, 3);
        instr_req = 1'b1;
        drain(60);

        // Redirect together with rvalid and a would-be pop
        step(5);
        rv_en = 1'b0;
        exp_q.push_back(32'h20C);
        instr_req = 1'b1;
        step(1);
        instr_req = 1'b0;
        step(3);
        rv_en = 1'b1;
        step(1);
        instr_req = 1'b1;
        redirect(32'h400);
        chk("rd_flush_valid", 32'(instr_valid), 32'd0);
        chk("rd_disc",        32'(dut.disc_cnt_q), 32'd0);
        push_seq(32'h400, 2);
        drain(60);

        // Address wrap, then reset asserted mid-burst
        step(5);
        redirect(32'hFFFF_FFFC);
        exp_q.push_back(32'hFFFF_FFFC);
        push_seq(32'h0, 2);
        instr_req = 1'b1;
        drain(60);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req",   32'(mem_req), 32'd0);
        chk("mid_rst_addr",  mem_addr, 32'h0);
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_instr", instr, 32'h0);
        chk("mid_rst_pc",    pc, 32'h0);
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage; sits directly upstream of the decoder and feeds it fetched words.
- Holds the fetch PC and issues word requests on a req/gnt/rvalid instruction-memory port.
- Buffers returned words in a small prefetch FIFO and presents them to the decoder with a valid/consume handshake.
- Accepts branch/jump redirects from the decoder, flushes the FIFO and drops stale in-flight responses.

Parameters:
- BOOT_ADDR, 32'h0000_0000, first fetch address after reset (word aligned).
- FIFO_DEPTH, 2, prefetch FIFO entries; also the cap on in-flight plus buffered words (legal values 2..4).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- instr_mem_req_o  out  1  memory request.
- instr_mem_addr_o  out  RISCV_ADDR_WIDTH  request address; bits [1:0] always 0.
- instr_mem_gnt_i  in  1  request accepted this cycle.
- instr_mem_rvalid_i  in  1  response data valid; responses return in order, at least 1 cycle after gnt.
- instr_mem_rdata_i  in  RISCV_WORD_WIDTH  response word.
- instr_o  out  RISCV_WORD_WIDTH  instruction to decoder (FIFO head).
- instr_valid_o  out  1  instr_o valid.
- pc_o  out  RISCV_ADDR_WIDTH  address of instr_o.
- instr_req_i  in  1  decoder consumes head when instr_valid_o=1.
- target_addr_i  in  RISCV_ADDR_WIDTH  redirect address; bits [1:0] ignored.
- target_valid_i  in  1  redirect strobe, one cycle.

Behaviour:
- Reset (async assert): instr_mem_req_o=0, instr_mem_addr_o=BOOT_ADDR, instr_valid_o=0, instr_o=0, pc_o=BOOT_ADDR. FIFO is empty; outstanding and discard counters are 0.
- Next-fetch register npc is initialised to BOOT_ADDR. instr_mem_req_o asserts in the first cycle after rst_n deasserts.
- Request rule: req asserts when no request is pending and (FIFO count + outstanding) < FIFO_DEPTH.
  - Once asserted, req and addr are held stable until gnt. A pending request is never withdrawn.
  - On gnt, npc += 4, wrapping modulo 2^32, and outstanding increments.
  - A new request may assert in the cycle after gnt. Gnt in the same cycle as req is legal.
- Response rule: on rvalid, outstanding decrements.
  - If discard_cnt > 0, the word is dropped and discard_cnt decrements.
  - Otherwise the word is pushed to the FIFO tagged with its request address.
  - rvalid with an empty FIFO becomes visible on instr_valid_o the next cycle; there is no combinational bypass.
- Decoder handshake: the head is popped when instr_valid_o && instr_req_i && !target_valid_i. Push and pop in the same cycle are allowed when the FIFO is full.
- Redirect (target_valid_i=1), all effects in the same cycle:
  - The FIFO is flushed, and instr_valid_o=0 from the next cycle.
  - npc <= {target_addr_i[31:2],2'b00}.
  - discard_cnt <= outstanding after this cycle's gnt/rvalid updates. An rvalid arriving in the redirect cycle is itself discarded.
  - An ungranted pending request stays on the bus with its old address and is counted for discard when granted.
  - The first request to the target asserts the cycle after the redirect, or after the stale pending request is granted.
- Redirect priority: redirect beats a pop and a push in the same cycle. A second redirect while stale responses are still pending adds to the discard count; nothing is double counted.
- Minimum redirect-to-valid latency with same-cycle gnt and 1-cycle rvalid:
  - t: redirect
  - t+1: req/gnt
  - t+2: rvalid
  - t+3: instr_valid_o
- Overflow is impossible by the request rule; an assertion checks it. rvalid with outstanding=0 is a protocol error, also asserted.
- FSM, 2 states:
  - RUN: normal.
  - FLUSH: discard_cnt > 0; requests to the new npc may issue but their data cannot push until FLUSH exits.
  - Transitions: RUN->FLUSH on redirect with nonzero computed discard count. FLUSH->RUN when discard_cnt reaches 0.

Decomposition:
- The riscv_defines package supplies RISCV_WORD_WIDTH and RISCV_ADDR_WIDTH (both 32). Add RISCV_INSTR_BYTES=4 and a fetch-entry struct {addr, instr} there.
- One sub-module, fetch_fifo: parameterised depth; push/pop/flush; count, full, empty outputs; head data out. It is synchronous apart from the async active-low reset.

Test Plan:
- Reset release with gnt tied 1 and 1-cycle rvalid, instr_req_i=1 -> addresses 0x0, 0x4, 0x8... issued; instr_valid_o first high on cycle 3 after reset with pc_o=0x0; one instruction per cycle thereafter.
- Decoder stalls (instr_req_i=0) -> at most 2 words buffered plus 0 in flight; req drops; FIFO head held stable; resuming yields no lost or duplicated pc.
- Redirect to 0x100 with 2 responses in flight -> both dropped; next valid word has pc_o=0x100; discard_cnt returns to 0 and the FSM returns to RUN.
- Redirect while req pending ungranted (gnt low 3 cycles) at addr 0x20 -> addr 0x20 held until gnt, its data discarded, then request 0x200 (target 0x202 masked).
- Redirect in the same cycle as rvalid and pop -> FIFO empty next cycle; no pop counted.
- npc=0xFFFF_FFFC fetch -> next request address 0x0000_0000; rst_n asserted mid-burst -> all outputs return to reset values immediately.
